present_frame_loader: RTL and testbench

- Upstream stage of the PRESENT-80 encryption core. Sits between a byte-wide host interface (UART/FIFO side) and the core's master_key / plain_text / rst / start / ended interface.
- Parses command-framed bytes, assembles the 80-bit key and 64-bit plaintext, then sequences a core reset and start.
- Waits for the core's ended flag, or a timeout, before accepting the next frame.

---
 rtl/present_pkg.sv | 21 ++
 rtl/present_byte_shifter.sv | 51 +++++
 rtl/present_frame_loader.sv | 158 +++++++++++++++
 tb/tb_present_frame_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants, default command bytes and state encoding for the
// PRESENT-80 frame loader.
package present_pkg;

    localparam int KEY_W     = 80;
    localparam int BLK_W     = 64;
    localparam int KEY_BYTES = KEY_W / 8;
    localparam int BLK_BYTES = BLK_W / 8;

    localparam logic [7:0] CMD_KEY_DEF = 8'h4B;
    localparam logic [7:0] CMD_PT_DEF  = 8'h50;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_KEY = 3'd1,
        LOAD_PT  = 3'd2,
        PRE      = 3'd3,
        RUN      = 3'd4
    } state_t;

endpackage

// File: rtl/present_byte_shifter.sv
// MSB-first byte assembler: byte k of a frame lands in data[W-1-8k -: 8].
// last is high while the final byte of the frame is being loaded.
module present_byte_shifter #(
    parameter int W = 80,
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_en,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] data,
    output logic         last
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;

    assign last = load_en && (cnt_q == CNT_LAST);
    assign data = data_q;

    // Only the addressed byte lane changes; the rest of the word holds.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load_en) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
            for (int k = 0; k < N; k++) begin
                if (cnt_q == CW'(k)) begin
                    data_d[W-1-8*k -: 8] = byte_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/present_frame_loader.sv
// Host byte-stream front end for the PRESENT-80 core: parses KEY/PT frames,
// then sequences core reset, start, and waits for ended or a timeout.
module present_frame_loader
    import present_pkg::*;
#(
    parameter int unsigned CORE_RST_CYC = 2,
    parameter int unsigned TIMEOUT_CYC  = 1024,
    parameter logic [7:0]  CMD_KEY      = CMD_KEY_DEF,
    parameter logic [7:0]  CMD_PT       = CMD_PT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             core_ended,
    output logic [KEY_W-1:0] master_key,
    output logic [BLK_W-1:0] plain_text,
    output logic             core_rst,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             err_cmd,
    output logic             err_timeout
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [3:0]      PRE_LAST = 4'(CORE_RST_CYC - 1);

    state_t          state_q, state_d;
    logic [3:0]      pre_cnt_q, pre_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            core_rst_q, core_rst_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_cmd_q, err_cmd_d;
    logic            err_to_q, err_to_d;

    logic accept, cmd_accept, key_load, pt_load, key_last, pt_last;

    // Held low during reset so the host cannot push a byte that is then lost.
    assign in_ready   = !rst && (state_q == IDLE || state_q == LOAD_KEY || state_q == LOAD_PT);
    assign accept     = in_valid && in_ready;
    assign cmd_accept = accept && (state_q == IDLE);
    assign key_load   = accept && (state_q == LOAD_KEY);
    assign pt_load    = accept && (state_q == LOAD_PT);

    present_byte_shifter #(.W(KEY_W), .N(KEY_BYTES)) u_key_shifter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cmd_accept),
        .load_en (key_load),
        .byte_in (in_data),
        .data    (master_key),
        .last    (key_last)
    );

    present_byte_shifter #(.W(BLK_W), .N(BLK_BYTES)) u_pt_shifter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cmd_accept),
        .load_en (pt_load),
        .byte_in (in_data),
        .data    (plain_text),
        .last    (pt_last)
    );

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        to_cnt_d  = to_cnt_q;
        done_d    = 1'b0;
        err_cmd_d = 1'b0;
        err_to_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (in_data == CMD_KEY) begin
                        state_d = LOAD_KEY;
                    end else if (in_data == CMD_PT) begin
                        state_d = LOAD_PT;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
            end
            LOAD_KEY: begin
                if (key_last) begin
                    state_d = IDLE;
                end
            end
            LOAD_PT: begin
                if (pt_last) begin
                    state_d   = PRE;
                    pre_cnt_d = '0;
                end
            end
            PRE: begin
                if (pre_cnt_q == PRE_LAST) begin
                    state_d  = RUN;
                    to_cnt_d = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + 4'd1;
                end
            end
            RUN: begin
                // ended takes priority over a timeout landing in the same cycle
                if (core_ended) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (TIMEOUT_CYC != 0 && to_cnt_q == TO_LAST) begin
                    state_d  = IDLE;
                    err_to_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        core_rst_d = (state_d == PRE);
        start_d    = (state_d == RUN);
        busy_d     = core_rst_d || start_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            to_cnt_q   <= '0;
            core_rst_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_cmd_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            to_cnt_q   <= to_cnt_d;
            core_rst_q <= core_rst_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_cmd_q  <= err_cmd_d;
            err_to_q   <= err_to_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_cmd     = err_cmd_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_present_frame_loader.sv
// Directed bench for present_frame_loader: byte-array reference model compared
// every cycle, plus literal expectations for each scenario.
module tb_present_frame_loader;

    localparam int RST_CYC = 2;
    localparam int TO_CYC  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        core_ended = 1'b0;
    logic [79:0] master_key;
    logic [63:0] plain_text;
    logic        core_rst, start, busy, done, err_cmd, err_timeout;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    present_frame_loader #(
        .CORE_RST_CYC (RST_CYC),
        .TIMEOUT_CYC  (TO_CYC),
        .CMD_KEY      (8'h4B),
        .CMD_PT       (8'h50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .core_ended  (core_ended),
        .master_key  (master_key),
        .plain_text  (plain_text),
        .core_rst    (core_rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: frame bytes kept as arrays, launch timing as cycle ages.
    typedef enum int {M_IDLE, M_KEY, M_PT, M_PRE, M_RUN} phase_t;
    phase_t     m_phase = M_IDLE;
    int         m_idx = 0;
    int         m_age = 0;
    logic [7:0] m_key [10];
    logic [7:0] m_pt  [8];
    logic       m_done = 1'b0, m_err_cmd = 1'b0, m_err_to = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= M_IDLE;
            m_idx     <= 0;
            m_age     <= 0;
            m_done    <= 1'b0;
            m_err_cmd <= 1'b0;
            m_err_to  <= 1'b0;
            for (int i = 0; i < 10; i++) m_key[i] <= 8'h00;
            for (int i = 0; i < 8; i++) m_pt[i] <= 8'h00;
        end else begin
            m_done    <= 1'b0;
            m_err_cmd <= 1'b0;
            m_err_to  <= 1'b0;
            case (m_phase)
                M_IDLE: if (in_valid) begin
                    if (in_data == 8'h4B) begin
                        m_phase <= M_KEY;
                        m_idx   <= 0;
                    end else if (in_data == 8'h50) begin
                        m_phase <= M_PT;
                        m_idx   <= 0;
                    end else begin
                        m_err_cmd <= 1'b1;
                    end
                end
                M_KEY: if (in_valid) begin
                    m_key[m_idx] <= in_data;
                    m_idx <= m_idx + 1;
                    if (m_idx == 9) m_phase <= M_IDLE;
                end
                M_PT: if (in_valid) begin
                    m_pt[m_idx] <= in_data;
                    m_idx <= m_idx + 1;
                    if (m_idx == 7) begin
                        m_phase <= M_PRE;
                        m_age   <= 0;
                    end
                end
                M_PRE: begin
                    if (m_age + 1 == RST_CYC) begin
                        m_phase <= M_RUN;
                        m_age   <= 0;
                    end else begin
                        m_age <= m_age + 1;
                    end
                end
                M_RUN: begin
                    if (core_ended) begin
                        m_phase <= M_IDLE;
                        m_done  <= 1'b1;
                    end else if (m_age + 1 == TO_CYC) begin
                        m_phase  <= M_IDLE;
                        m_err_to <= 1'b1;
                    end else begin
                        m_age <= m_age + 1;
                    end
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    function automatic logic [159:0] exp_vec();
        logic [79:0] k;
        logic [63:0] p;
        logic        rdy;
        for (int i = 0; i < 10; i++) k[79-8*i -: 8] = m_key[i];
        for (int i = 0; i < 8; i++) p[63-8*i -: 8] = m_pt[i];
        rdy = !rst && (m_phase == M_IDLE || m_phase == M_KEY || m_phase == M_PT);
        return {9'd0, rdy, m_phase == M_PRE, m_phase == M_RUN,
                (m_phase == M_PRE || m_phase == M_RUN), m_done, m_err_cmd, m_err_to, k, p};
    endfunction

    function automatic logic [159:0] dut_vec();
        return {9'd0, in_ready, core_rst, start, busy, done, err_cmd, err_timeout,
                master_key, plain_text};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) check("outputs_vs_model", dut_vec(), exp_vec());
    end

    // Event counters for the literal expectations.
    int n_rst_cyc = 0, n_start_cyc = 0, n_done = 0, n_err_cmd = 0, n_err_to = 0;
    int n_bp = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (core_rst) n_rst_cyc <= n_rst_cyc + 1;
            if (start) n_start_cyc <= n_start_cyc + 1;
            if (done) n_done <= n_done + 1;
            if (err_cmd) n_err_cmd <= n_err_cmd + 1;
            if (err_timeout) n_err_to <= n_err_to + 1;
            if (busy && in_ready) n_bp <= n_bp + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) check("in_ready_wait_budget", 160'd0, 160'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int waited;
        waited = 0;
        while (!start && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!start) check("start_wait_budget", 160'd0, 160'd1);
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (busy && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (busy) check("idle_wait_budget", 160'd0, 160'd1);
    endtask

    // Core asserts ended after start has been seen high for k further edges.
    task automatic respond(input int k);
        wait_start();
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        core_ended = 1'b1;
        @(posedge clk);
        #1;
        core_ended = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    int b_rst, b_start, b_done, b_cmd, b_to, b_bp;
    task automatic snap();
        b_rst = n_rst_cyc; b_start = n_start_cyc; b_done = n_done;
        b_cmd = n_err_cmd; b_to = n_err_to; b_bp = n_bp;
    endtask

    initial begin
        rst = 1'b1;
        #2;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_outputs", dut_vec(), {9'd0, 1'b1, 6'd0, 80'd0, 64'd0});

        // 1: zero key then a PT frame with launch
        snap();
        send_byte(8'h4B);
        for (int i = 0; i < 10; i++) send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h77); send_byte(8'h77); send_byte(8'hAA); send_byte(8'hAA);
        send_byte(8'h33); send_byte(8'h33); send_byte(8'hEE); send_byte(8'hEE);
        respond(3);
        check("s1_plain_text", 160'(plain_text), 160'(64'h7777aaaa3333eeee));
        check("s1_master_key", 160'(master_key), 160'd0);
        check("s1_core_rst_cycles", 160'(n_rst_cyc - b_rst), 160'd2);
        check("s1_start_cycles", 160'(n_start_cyc - b_start), 160'd4);
        check("s1_done_pulses", 160'(n_done - b_done), 160'd1);
        check("s1_ready_while_busy", 160'(n_bp - b_bp), 160'd0);

        // 2: key reuse
        snap();
        send_byte(8'h50);
        for (int i = 0; i < 8; i++) send_byte(8'hBA);
        respond(1);
        check("s2_plain_text", 160'(plain_text), 160'(64'hBABABABABABABABA));
        check("s2_master_key", 160'(master_key), 160'd0);
        check("s2_core_rst_cycles", 160'(n_rst_cyc - b_rst), 160'd2);
        check("s2_done_pulses", 160'(n_done - b_done), 160'd1);

        // 3: bad command then a key frame, no launch
        snap();
        send_byte(8'h13);
        send_byte(8'h4B);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("s3_err_cmd_pulses", 160'(n_err_cmd - b_cmd), 160'd1);
        check("s3_master_key", 160'(master_key), 160'(80'h0102030405060708090A));
        check("s3_no_launch", 160'(n_rst_cyc - b_rst), 160'd0);

        // 4: timeout, then ended colliding with timeout
        snap();
        send_byte(8'h50);
        for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i));
        wait_start();
        wait_idle();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("s4_plain_text", 160'(plain_text), 160'(64'hC0C1C2C3C4C5C6C7));
        check("s4_start_cycles", 160'(n_start_cyc - b_start), 160'd16);
        check("s4_err_timeout_pulses", 160'(n_err_to - b_to), 160'd1);
        check("s4_no_done", 160'(n_done - b_done), 160'd0);
        check("s4_in_ready_after", 160'(in_ready), 160'd1);

        snap();
        send_byte(8'h50);
        for (int i = 0; i < 8; i++) send_byte(8'h5A);
        respond(15);
        check("s4b_done_pulses", 160'(n_done - b_done), 160'd1);
        check("s4b_no_timeout", 160'(n_err_to - b_to), 160'd0);
        check("s4b_start_cycles", 160'(n_start_cyc - b_start), 160'd16);

        // 6: backpressure during RUN, held byte becomes the next command
        snap();
        send_byte(8'h50);
        for (int i = 0; i < 8; i++) send_byte(8'h01);
        wait_start();
        in_valid = 1'b1;
        in_data  = 8'h4B;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        core_ended = 1'b1;
        @(posedge clk);
        #1;
        core_ended = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h11 + i));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("s6_ready_while_busy", 160'(n_bp - b_bp), 160'd0);
        check("s6_err_cmd_pulses", 160'(n_err_cmd - b_cmd), 160'd0);
        check("s6_master_key", 160'(master_key), 160'(80'h1112131415161718191A));
        check("s6_done_pulses", 160'(n_done - b_done), 160'd1);

        // 5: asynchronous reset mid-frame, then a clean launch
        send_byte(8'h50);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        rst = 1'b1;
        #1;
        check("s5_async_reset_outputs", dut_vec(), {9'd0, 1'b0, 6'd0, 80'd0, 64'd0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        snap();
        send_byte(8'h50);
        for (int i = 0; i < 8; i++) send_byte(8'(8'hD0 + i));
        respond(2);
        check("s5_plain_text", 160'(plain_text), 160'(64'hD0D1D2D3D4D5D6D7));
        check("s5_master_key", 160'(master_key), 160'd0);
        check("s5_core_rst_cycles", 160'(n_rst_cyc - b_rst), 160'd2);
        check("s5_done_pulses", 160'(n_done - b_done), 160'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
